// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver presenting bytes over a ready/valid
// handshake, with single-cycle framing-error and overrun pulses.
module uart_receiver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int CPS    = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE = CPS / 2;
    localparam int CNT_W  = (CPS > 2) ? $clog2(CPS) : 1;

    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CPS - 1);

    generate
        if (CPS < 4) begin : g_cps_check
            $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample_pt;
    logic             bit_end;
    logic             commit;
    logic             frame_bad;

    assign sample_pt = (cnt == CNT_SAMPLE);
    assign bit_end   = (cnt == CNT_LAST);
    assign busy      = (state != IDLE);

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STOP leaves at its sample point so a start bit straight after is not missed.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_pt && rx_s) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_pt) begin
                    state_next = IDLE;
                    if (rx_s) begin
                        commit = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if ((state == IDLE) || (state_next != state) || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if ((state == DATA) && sample_pt) begin
                shift <= {rx_s, shift[7:1]};
            end
        end
    end

    // A commit may replace a byte only if the consumer takes the old one in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= 1'b0;
            if (commit) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shift;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames on serial_in and checks delivered bytes
// and error pulses against expectations built from the frames sent.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CPS = 5;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_bytes;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         busy_cycles = 0;

    uart_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #10 clk = ~clk;

    // Monitor: records accepted bytes and pulse counts just after each falling edge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (data_out_valid && data_out_ready) got_q.push_back(data_out);
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (busy) busy_cycles++;
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        serial_in = b;
        repeat (CPS) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
        sendBit(stop_bit);
        serial_in = 1'b1;
    endtask

    task automatic clearMon();
        got_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        busy_cycles = 0;
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] b2b[5];
        logic [7:0] exp_q[$];
        int         exp_fe;
        int         n;

        vecs[0] = '{8'h61, 1'b1, 1, 8'h61, 0};
        vecs[1] = '{8'hA5, 1'b0, 0, 8'h00, 1};
        vecs[2] = '{8'h3E, 1'b1, 1, 8'h3E, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 8'h00, 1};
        b2b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h20};

        waitCycles(2);
        checkOutput("reset data_out", data_out, 8'h00);
        checkOutput("reset valid", data_out_valid, 0);
        checkOutput("reset framing_error", framing_error, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset busy", busy, 0);
        rst = 1'b1;
        waitCycles(5);

        for (int i = 0; i < 6; i++) begin
            clearMon();
            applyStimulus(vecs[i].data, vecs[i].stop_bit);
            waitCycles(15);
            checkOutput($sformatf("vec%0d byte count", i), got_q.size(), vecs[i].exp_bytes);
            if (vecs[i].exp_bytes > 0 && got_q.size() > 0)
                checkOutput($sformatf("vec%0d data", i), got_q[0], vecs[i].exp_data);
            checkOutput($sformatf("vec%0d framing_error count", i), fe_cnt, vecs[i].exp_fe);
            checkOutput($sformatf("vec%0d overrun count", i), ov_cnt, 0);
            checkOutput($sformatf("vec%0d valid after", i), data_out_valid, 0);
        end

        clearMon();
        for (int i = 0; i < 5; i++) applyStimulus(b2b[i], 1'b1);
        waitCycles(15);
        checkOutput("b2b byte count", got_q.size(), 5);
        n = (got_q.size() < 5) ? got_q.size() : 5;
        for (int i = 0; i < n; i++) checkOutput($sformatf("b2b byte%0d", i), got_q[i], b2b[i]);
        checkOutput("b2b framing_error count", fe_cnt, 0);

        clearMon();
        data_out_ready = 1'b0;
        applyStimulus(8'h73, 1'b1);
        waitCycles(5);
        checkOutput("hold first valid", data_out_valid, 1);
        checkOutput("hold first data", data_out, 8'h73);
        applyStimulus(8'h77, 1'b1);
        waitCycles(5);
        checkOutput("overrun data kept", data_out, 8'h73);
        checkOutput("overrun valid kept", data_out_valid, 1);
        checkOutput("overrun pulse count", ov_cnt, 1);
        checkOutput("overrun no accept", got_q.size(), 0);
        data_out_ready = 1'b1;
        waitCycles(1);
        checkOutput("accept drops valid", data_out_valid, 0);
        checkOutput("accept byte count", got_q.size(), 1);
        if (got_q.size() > 0) checkOutput("accept byte", got_q[0], 8'h73);

        clearMon();
        serial_in = 1'b0;
        waitCycles(2);
        serial_in = 1'b1;
        waitCycles(20);
        checkOutput("glitch no byte", got_q.size(), 0);
        checkOutput("glitch no error", fe_cnt, 0);
        checkOutput("glitch busy brief", (busy_cycles > 0) && (busy_cycles < 4), 1);

        clearMon();
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        serial_in = 1'b0;
        waitCycles(2);
        checkOutput("mid-frame busy", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("async reset data_out", data_out, 8'h00);
        checkOutput("async reset valid", data_out_valid, 0);
        checkOutput("async reset framing_error", framing_error, 0);
        checkOutput("async reset overrun", overrun, 0);
        checkOutput("async reset busy", busy, 0);
        serial_in = 1'b1;
        waitCycles(3);
        rst = 1'b1;
        waitCycles(20);
        applyStimulus(8'h0D, 1'b1);
        waitCycles(15);
        checkOutput("after reset byte count", got_q.size(), 1);
        if (got_q.size() > 0) checkOutput("after reset byte", got_q[0], 8'h0D);
        checkOutput("after reset framing_error", fe_cnt, 0);

        clearMon();
        serial_in = 1'b0;
        waitCycles(150);
        checkOutput("held low repeats framing_error", fe_cnt >= 2, 1);
        checkOutput("held low no byte", got_q.size(), 0);
        serial_in = 1'b1;
        waitCycles(60);
        clearMon();
        applyStimulus(8'h55, 1'b1);
        waitCycles(15);
        checkOutput("recover byte count", got_q.size(), 1);
        if (got_q.size() > 0) checkOutput("recover byte", got_q[0], 8'h55);

        // Reference: every frame with a high stop bit delivers its byte in order,
        // every frame with a low stop bit yields exactly one framing error.
        clearMon();
        exp_fe = 0;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       s;
            int         gap;
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            applyStimulus(d, s);
            if (s) exp_q.push_back(d);
            else exp_fe++;
            gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
            waitCycles(gap * CPS);
        end
        waitCycles(20);
        checkOutput("random byte count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) checkOutput($sformatf("random byte%0d", i), got_q[i], exp_q[i]);
        checkOutput("random framing_error count", fe_cnt, exp_fe);
        checkOutput("random overrun count", ov_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- On-chip serial receiver: deserializes 8N1 frames arriving on the FPGA serial_in pin, as driven by the host.
- Presents each received byte to the CPU memory-mapped UART logic through a ready/valid handshake.
- Flags framing errors and overruns as single-cycle pulses.
- Receive-side counterpart of the host transmitter used by the BIOS bench; shares the CPU clock.

Parameters:
- CLOCK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 10_000_000: line rate in bit/s.
- Derived, not overridable: CPS = CLOCK_FREQ/BAUD_RATE (integer division, floor). SAMPLE = CPS/2 (floor). CPS >= 4 is required; an elaboration-time check stops otherwise.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- serial_in  input  1  async line, idle high.
- data_out  output  8  received byte, LSB = first data bit.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts the byte on the cycle where valid && ready.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte arrived while valid was high and not consumed.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, counters=0, data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0, busy=0.
  - Synchronizer flops reset to 1.
  - A reset that lands mid-frame discards the partial byte; that frame is not resumed after reset.
- Input path: serial_in passes through a 2-flop synchronizer (rx_s). All decisions use rx_s; 2-cycle input latency.
- Symbol counter: cnt runs 0..CPS-1 inside each bit. Sampling happens on the cycle where cnt==SAMPLE.
- IDLE:
  - rx_s==0 -> START, cnt=0, busy=1 from the next cycle.
- START:
  - At cnt==SAMPLE: rx_s==1 -> glitch, return to IDLE with no output. rx_s==0 -> continue.
  - At cnt==CPS-1 -> DATA, bit index=0.
- DATA:
  - At cnt==SAMPLE: shift rx_s into the shift register, LSB first.
  - At cnt==CPS-1: index 7 -> STOP; otherwise index+1.
- STOP:
  - At cnt==SAMPLE, the FSM returns to IDLE on the next cycle. It does not wait for the end of the stop bit, so back-to-back frames are accepted.
  - rx_s==1: commit the byte.
  - rx_s==0: pulse framing_error for 1 cycle, drop the byte, leave data_out and valid unchanged.
- Commit, evaluated in the commit cycle:
  - valid==0: data_out<=byte, valid<=1.
  - valid==1 && ready==1: old byte consumed, new byte loaded; valid stays 1.
  - valid==1 && ready==0: new byte dropped, old byte kept, overrun pulses 1 cycle.
- Handshake:
  - valid falls the cycle after valid&&ready, unless a simultaneous commit reloads it.
  - data_out is stable while valid=1 and not accepted.
  - ready while valid=0 has no effect.
- Latency: valid rises 3 cycles after the stop-bit sample point on the raw pin (2 sync + 1 register).
- Line held low forever: an all-zero frame yields framing_error. The FSM then re-enters START from IDLE, repeating every 10 symbols. No lock-up.

Test Plan (defaults; CPS=5, SAMPLE=2, bit period 100 ns, 50 MHz clk):
- Host sends 8'h61 as 8N1 with ready held 1 -> exactly one valid pulse with data_out=8'h61; framing_error=0, overrun=0.
- Host sends 'a','b','c','d',' ' back-to-back (stop bit then immediate start), ready=1 -> bytes 61,62,63,64,20 in order, no errors.
- Ready held 0 while host sends 8'h73 then 8'h77 -> data_out stays 8'h73 with valid=1, overrun pulses once. Asserting ready then -> valid drops next cycle.
- Frame 8'hA5 with stop bit driven 0 -> framing_error 1-cycle pulse, valid stays 0. A following 8'h3E frame is then received correctly.
- 40 ns low glitch on an idle line -> returns to IDLE, no valid, no error; busy high for fewer than 4 cycles.
- rst asserted low mid-data-bit of 8'hCA, released, then 8'h0D sent -> all outputs 0 during reset; only 8'h0D is delivered.
